// File: rtl/fifo_ctr_dp.sv
// rtl/fifo_ctr_dp.sv - FIFO controller for an external synchronous dual-port SRAM
// Optional sticky error register enabled by defining FIFO_CTR_STICKY_ERR_EN.
module fifo_ctr_dp #(
  parameter int ADDR_W = 5,
  parameter int AE_TH  = 1,
  parameter int AF_TH  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic              empty,
  output logic              almost_empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              error,
  output logic              wcen,
  output logic [ADDR_W-1:0] waddr,
  output logic              rcen,
  output logic [ADDR_W-1:0] raddr,
  output logic              rvalid
);

  localparam int CW    = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AE_HI   = CW'(AE_TH);
  localparam logic [CW-1:0] AF_LO   = CW'(DEPTH - AF_TH);
  localparam logic [CW-1:0] AF_HI   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [CW-1:0]     count_q;
  logic              rvalid_q;

  logic full_w;
  logic empty_w;
  logic push_ok;
  logic pop_ok;
  logic err_now;

  // Flags decode the count register only, so they never glitch on request inputs.
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  assign push_ok = push & ~full_w;
  assign pop_ok  = pop & ~empty_w;
  assign err_now = (push & full_w) | (pop & empty_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      tail     <= tail + ADDR_W'(push_ok);
      head     <= head + ADDR_W'(pop_ok);
      count_q  <= count_q + CW'(push_ok) - CW'(pop_ok);
      rvalid_q <= pop_ok;
    end
  end

  assign empty        = empty_w;
  assign full         = full_w;
  assign almost_empty = (count_q >= ONE_C) && (count_q <= AE_HI);
  assign almost_full  = (count_q >= AF_LO) && (count_q <= AF_HI);
  assign count        = count_q;

  assign wcen   = ~push_ok;
  assign rcen   = ~pop_ok;
  assign waddr  = tail;
  assign raddr  = head;
  assign rvalid = rvalid_q;

`ifdef FIFO_CTR_STICKY_ERR_EN
  logic error_q;

  // A new rejection in the same cycle as err_clr keeps the error set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (err_now) begin
      error_q <= 1'b1;
    end else if (err_clr) begin
      error_q <= 1'b0;
    end
  end

  assign error = error_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign error          = err_now;
`endif

endmodule

// File: tb/tb_fifo_ctr_dp.sv
// tb/tb_fifo_ctr_dp.sv - directed and randomized bench for fifo_ctr_dp against a queue model
module tb_fifo_ctr_dp;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int AE_TH  = 1;
  localparam int AF_TH  = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic              err_clr = 1'b0;
  logic              empty;
  logic              almost_empty;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              error;
  logic              wcen;
  logic [ADDR_W-1:0] waddr;
  logic              rcen;
  logic [ADDR_W-1:0] raddr;
  logic              rvalid;

  fifo_ctr_dp #(.ADDR_W(ADDR_W), .AE_TH(AE_TH), .AF_TH(AF_TH)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .err_clr(err_clr),
    .empty(empty), .almost_empty(almost_empty), .full(full), .almost_full(almost_full),
    .count(count), .error(error), .wcen(wcen), .waddr(waddr), .rcen(rcen),
    .raddr(raddr), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

`ifdef FIFO_CTR_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  int passed = 0;
  int total  = 0;

  // Reference: queue of SRAM addresses currently holding valid entries, oldest first.
  int q[$];
  int tail_m   = 0;
  bit rvalid_m = 1'b0;
  bit err_m    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step(input bit p, input bit o, input bit c);
    int n;
    bit pok, ook, en;
    @(negedge clk);
    push = p; pop = o; err_clr = c;
    #1;
    n   = q.size();
    pok = p && (n < DEPTH);
    ook = o && (n > 0);
    en  = (p && n == DEPTH) || (o && n == 0);
    chk("count", 32'(count), n);
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("almost_empty", 32'(almost_empty), 32'(n >= 1 && n <= AE_TH));
    chk("almost_full", 32'(almost_full), 32'(n >= DEPTH - AF_TH && n <= DEPTH - 1));
    chk("wcen", 32'(wcen), 32'(!pok));
    chk("rcen", 32'(rcen), 32'(!ook));
    chk("waddr", 32'(waddr), tail_m);
    if (n > 0) chk("raddr", 32'(raddr), q[0]);
    else       chk("raddr_empty", 32'(raddr), tail_m);
    chk("rvalid", 32'(rvalid), 32'(rvalid_m));
    chk("error", 32'(error), STICKY ? 32'(err_m) : 32'(en));
    @(posedge clk);
    if (pok) begin
      q.push_back(tail_m);
      tail_m = (tail_m + 1) % DEPTH;
    end
    if (ook) void'(q.pop_front());
    rvalid_m = ook;
    if (STICKY) err_m = en ? 1'b1 : (c ? 1'b0 : err_m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_wcen", 32'(wcen), 1);
    chk("rst_rcen", 32'(rcen), 1);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_raddr", 32'(raddr), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_error", 32'(error), 0);
    q.delete();
    tail_m = 0; rvalid_m = 1'b0; err_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0);

    // Reset while a burst is in flight.
    repeat (10) step(1, 0, 0);
    step(0, 1, 0);
    do_reset();
    step(0, 0, 0);

    // Fill past full, then drain past empty.
    repeat (DEPTH + 1) step(1, 0, 0);
    repeat (DEPTH + 1) step(0, 1, 0);
    step(0, 0, 0);

    // Boundary concurrency at empty and at full.
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    repeat (DEPTH) step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);

    // Concurrent access across the address wrap: head=29, tail=2.
    do_reset();
    repeat (29) step(1, 0, 0);
    repeat (29) step(0, 1, 0);
    repeat (5) step(1, 0, 0);
    repeat (4) step(1, 1, 0);
    step(0, 0, 0);
    chk("wrap_count", 32'(count), 5);
    chk("wrap_raddr", 32'(raddr), 1);
    chk("wrap_waddr", 32'(waddr), 6);

    // Error on underflow, then sticky hold/clear behaviour where built in.
    repeat (5) step(0, 1, 0);
    step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    repeat (DEPTH) step(1, 0, 0);
    step(1, 0, 1);
    repeat (3) step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);

    // Randomized traffic with phases biased toward filling, balancing and draining.
    for (int i = 0; i < 3000; i++) begin
      int pp;
      case ((i / 200) % 3)
        0:       pp = 80;
        1:       pp = 50;
        default: pp = 20;
      endcase
      step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < (100 - pp),
           $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
